// File: rtl/cubehash_pkg.sv
// Shared definitions for the CubeHash round-state controller: state encoding,
// default geometry and the round counter width.
package cubehash_pkg;

  localparam int BLOCK_W_DEF  = 256;
  localparam int R_ROUNDS_DEF = 16;
  localparam int F_ROUNDS_DEF = 160;
  localparam int CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREP   = 3'd1,
    ST_ABSORB = 3'd2,
    ST_ROUND  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_FINAL  = 3'd5,
    ST_OUT    = 3'd6
  } state_t;

endpackage

// File: rtl/cubehash_round_cnt.sv
// Round counter: clears on every controller state change, counts while enabled,
// and flags the last cycle of a phase whose length is given by limit.
module cubehash_round_cnt
  import cubehash_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // tc is high during the final cycle of a limit-cycle phase.
  assign tc = (cnt == (limit - CNT_W'(1)));

endmodule

// File: rtl/cubehash_ctrl.sv
// CubeHash control FSM: accepts message blocks, sequences absorb/round/final
// phases and drives the strobes of the external round-state block.
module cubehash_ctrl
  import cubehash_pkg::*;
#(
  parameter int BLOCK_W  = BLOCK_W_DEF,
  parameter int R_ROUNDS = R_ROUNDS_DEF,
  parameter int F_ROUNDS = F_ROUNDS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_last,
  output logic               blk_ready,
  output logic [BLOCK_W-1:0] block,
  output logic               start1,
  output logic               in_en,
  output logic               done,
  output logic               xor_fin,
  output logic               out_en,
  output logic               stop_process,
  output logic               busy,
  output state_t             state_dbg
);

  // Handshake: a block transfers on a rising clk edge where blk_valid and
  // blk_ready are both high; blk_ready never depends on blk_valid, and
  // blk_valid outside IDLE/WAIT is simply left pending upstream.

  state_t           state, state_nxt;
  logic             last_q, first_q;
  logic             out_of_reset;
  logic             accept;
  logic             cnt_clear, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt, cnt_limit;

  assign accept    = blk_valid & blk_ready;
  assign cnt_clear = (state_nxt != state);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Keeps blk_ready low while rst_n is low without using rst_n as data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block   <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
    end else if (accept) begin
      block   <= blk_data;
      last_q  <= blk_last;
      first_q <= (state == ST_IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    blk_ready    = 1'b0;
    start1       = 1'b0;
    in_en        = 1'b0;
    done         = 1'b0;
    xor_fin      = 1'b0;
    out_en       = 1'b0;
    stop_process = 1'b1;
    busy         = 1'b1;
    cnt_en       = 1'b0;
    cnt_limit    = CNT_W'(F_ROUNDS);
    case (state)
      ST_IDLE, ST_WAIT: begin
        busy      = 1'b0;
        blk_ready = out_of_reset;
        if (blk_valid && out_of_reset) state_nxt = ST_PREP;
      end
      ST_PREP: begin
        in_en     = 1'b1;
        start1    = first_q;
        state_nxt = ST_ABSORB;
      end
      ST_ABSORB: begin
        done         = 1'b1;
        stop_process = 1'b0;
        state_nxt    = ST_ROUND;
      end
      ST_ROUND: begin
        // A non-final block leaves one round short; the next ABSORB supplies it.
        stop_process = 1'b0;
        cnt_en       = 1'b1;
        cnt_limit    = last_q ? CNT_W'(R_ROUNDS) : CNT_W'(R_ROUNDS - 1);
        if (cnt_tc) state_nxt = last_q ? ST_FINAL : ST_WAIT;
      end
      ST_FINAL: begin
        stop_process = 1'b0;
        cnt_en       = 1'b1;
        xor_fin      = (cnt == '0);
        if (cnt_tc) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_en    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  cubehash_round_cnt u_round_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .limit (cnt_limit),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

endmodule

// File: tb/tb_cubehash_ctrl.sv
// Bench for cubehash_ctrl: per-cycle output logs checked against a table of
// hand-computed checkpoints, plus reset and continuous-valid sequences.
module tb_cubehash_ctrl;
  import cubehash_pkg::*;

  localparam int BW = 256;
  localparam logic [BW-1:0] DA = {8{32'hA5A5_0001}};
  localparam logic [BW-1:0] DB = {8{32'h5A5A_0002}};
  localparam logic [BW-1:0] DC = {8{32'h1234_0003}};

  // Output packing: {in_en,start1,done,xor_fin,out_en,stop_process,blk_ready,busy}
  localparam logic [7:0] O_IDLE  = 8'h06;
  localparam logic [7:0] O_PREP1 = 8'hC5;
  localparam logic [7:0] O_PREP0 = 8'h85;
  localparam logic [7:0] O_ABS   = 8'h21;
  localparam logic [7:0] O_RND   = 8'h01;
  localparam logic [7:0] O_FIN1  = 8'h11;
  localparam logic [7:0] O_OUT   = 8'h0D;
  localparam logic [7:0] O_RST   = 8'h04;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          blk_valid = 1'b0;
  logic          blk_last = 1'b0;
  logic [BW-1:0] blk_data = '0;
  logic          blk_ready, start1, in_en, done, xor_fin, out_en, stop_process, busy;
  logic [BW-1:0] block;
  state_t        state_dbg;

  cubehash_ctrl #(.BLOCK_W(BW), .R_ROUNDS(16), .F_ROUNDS(160)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .blk_valid    (blk_valid),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .block        (block),
    .start1       (start1),
    .in_en        (in_en),
    .done         (done),
    .xor_fin      (xor_fin),
    .out_en       (out_en),
    .stop_process (stop_process),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int         scen;
    int         cyc;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  logic [7:0]    log_o [0:399];
  logic [BW-1:0] log_b [0:399];

  function automatic logic [7:0] pack_out();
    return {in_en, start1, done, xor_fin, out_en, stop_process, blk_ready, busy};
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Strobe exclusivity and stop_process gating, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert ($countones({done, xor_fin, out_en, in_en}) <= 1 && !((done | xor_fin) & stop_process))
        passes++;
      else $display("FAIL strobe_excl: got %b expected onehot0/ungated", {done, xor_fin, out_en, in_en, stop_process});
    end
  end

  // Driver: per-scenario input schedule, applied at the negedge starting cycle c.
  task automatic drive(input int scen, input int c);
    case (scen)
      0: begin
        if (c == 0) begin blk_valid = 1'b1; blk_last = 1'b1; blk_data = DA; end
        if (c == 1) blk_valid = 1'b0;
      end
      1: begin
        if (c == 0) begin blk_valid = 1'b1; blk_last = 1'b0; blk_data = DA; end
        if (c == 1) begin blk_last = 1'b1; blk_data = DB; end
        if (c == 19) blk_valid = 1'b0;
      end
      2: begin
        if (c == 0) begin blk_valid = 1'b1; blk_last = 1'b0; blk_data = DA; end
        if (c == 1) blk_valid = 1'b0;
        if (c == 68) begin blk_valid = 1'b1; blk_last = 1'b1; blk_data = DB; end
        if (c == 69) blk_valid = 1'b0;
      end
      default: begin
        if (c == 0) begin blk_valid = 1'b1; blk_last = 1'b1; blk_data = DC; end
      end
    endcase
  endtask

  task automatic run_scen(input int scen, input int ncyc);
    rst_n = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; blk_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      drive(scen, c);
      #1;
      log_o[c] = pack_out();
      log_b[c] = block;
    end
  endtask

  task automatic run_table(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen)
        check($sformatf("s%0d_c%0d", scen, vecs[i].cyc), BW'(log_o[vecs[i].cyc]), BW'(vecs[i].exp));
    end
  endtask

  function automatic void add(input int s, input int c, input logic [7:0] e);
    vec_t v;
    v.scen = s; v.cyc = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    int n_acc;

    // Single block, last=1
    add(0, 0, O_IDLE); add(0, 1, O_PREP1); add(0, 2, O_ABS); add(0, 3, O_RND);
    add(0, 18, O_RND); add(0, 19, O_FIN1); add(0, 20, O_RND); add(0, 178, O_RND);
    add(0, 179, O_OUT); add(0, 180, O_IDLE);
    // Two blocks, B offered immediately
    add(1, 0, O_IDLE); add(1, 1, O_PREP1); add(1, 2, O_ABS); add(1, 17, O_RND);
    add(1, 18, O_IDLE); add(1, 19, O_PREP0); add(1, 20, O_ABS); add(1, 36, O_RND);
    add(1, 37, O_FIN1); add(1, 196, O_RND); add(1, 197, O_OUT); add(1, 198, O_IDLE);
    // Two blocks, second withheld 50 cycles in WAIT
    add(2, 17, O_RND); add(2, 18, O_IDLE); add(2, 67, O_IDLE); add(2, 68, O_IDLE);
    add(2, 69, O_PREP0); add(2, 70, O_ABS); add(2, 86, O_RND); add(2, 87, O_FIN1);
    add(2, 246, O_RND); add(2, 247, O_OUT); add(2, 248, O_IDLE);

    run_scen(0, 181);
    run_table(0);
    check("s0_block", log_b[1], DA);

    run_scen(1, 199);
    run_table(1);
    check("s1_block_a", log_b[5], DA);
    check("s1_block_b", log_b[19], DB);

    run_scen(2, 249);
    run_table(2);
    n_acc = 0;
    for (int c = 18; c < 68; c++) if (log_o[c] !== O_IDLE) n_acc++;
    check("s2_stall_frozen", BW'(n_acc), BW'(0));

    // Reset during FINAL (cycle 80 of FINAL = cycle 99)
    run_scen(0, 100);
    check("rst_pre_final", BW'(log_o[99]), BW'(O_RND));
    rst_n = 1'b0;
    #1;
    check("rst_outs", BW'(pack_out()), BW'(O_RST));
    check("rst_block", block, '0);
    check("rst_state", BW'(state_dbg), BW'(ST_IDLE));
    @(negedge clk);
    #1;
    check("rst_held_ready", BW'(blk_ready), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    blk_valid = 1'b1; blk_last = 1'b1; blk_data = DC;
    #1;
    check("rst_idle_after", BW'(pack_out()), BW'(O_IDLE));
    @(negedge clk);
    blk_valid = 1'b0;
    #1;
    check("rst_first_again", BW'(pack_out()), BW'(O_PREP1));
    check("rst_block_c", block, DC);

    // blk_valid held high across messages: one acceptance per IDLE visit
    run_scen(3, 361);
    n_acc = 0;
    for (int c = 0; c < 361; c++) if (log_o[c][1]) n_acc++;
    check("s3_accept_count", BW'(n_acc), BW'(3));
    check("s3_accept_180", BW'(log_o[180][1]), BW'(1));
    check("s3_accept_360", BW'(log_o[360][1]), BW'(1));
    check("s3_prep_181", BW'(log_o[181]), BW'(O_PREP1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
